axi_core_master: RTL and testbench
==================================

# axi_core_master

Upstream master for the AXI slave memory pipeline. Takes one load/store request at a time from a core-side memory stage and drives the five `Axi_ift` channels on the `Master` modport. Returns read data or a write acknowledgement with the bus response code. Single outstanding transaction; no bursts.

## Interface
- `ADDR_WIDTH`, default 64: address width; must equal `mem_ift.ADDR_WIDTH`.
- `DATA_WIDTH`, default 64: data width; must equal `mem_ift.DATA_WIDTH`; strobe width is `DATA_WIDTH/8`.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  block can accept a request.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  byte address, passed through unchanged.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wmask`  in  DATA_WIDTH/8  write strobes.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 on write completion.
- `rsp_resp`  out  `BusPack::resp_t`  rresp or bresp of the completed transaction.
- `mem_ift`  `Axi_ift.Master`  AXI side.

## Operation
- FSM states: IDLE, R_ADDR, R_DATA, W_REQ, W_RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch addr, wdata, wmask and wen.
  - Go to W_REQ if wen, else R_ADDR.
- R_ADDR:
  - `r_request_valid`=1, `raddr`=latched addr.
  - On fire, go to R_DATA.
- R_DATA:
  - `r_reply_ready`=1.
  - On fire, register rdata and rresp, pulse `rsp_valid` next cycle, go to IDLE.
- W_REQ:
  - Assert `w_addr_request_valid` and `w_data_request_valid` together from entry.
  - Per-channel done flags drop each valid on its own fire; the channels may fire in the same cycle or in either order.
  - When both are done, go to W_RESP.
- W_RESP:
  - `w_reply_ready`=1.
  - On fire, register bresp, `rsp_rdata`=0, pulse `rsp_valid`, go to IDLE.
- AXI rules:
  - A valid is never deasserted before its fire.
  - Payload bits are driven from latched registers and are stable while valid.
  - A valid never waits on the matching ready.
- `req_ready` is low in every state except IDLE. Requests presented while busy are ignored, not queued.
- A write with `wmask`=0 is still issued on the bus.
- No alignment check.
- Width mismatch against `mem_ift` fails at elaboration or initial time via `$display` + `$finish`.

## Timing
- Reset values:
  - state IDLE; `req_ready`=1 (combinational from state).
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_resp`=OKAY (2'b00).
  - All AXI valids 0; all AXI readies 0.
  - Latched payload 0.
- Reset mid-transaction: next cycle all AXI valids and readies are 0, state is IDLE, and no `rsp_valid` pulse. The slave is reset on the same `rstn`.
- Read latency against the zero-wait slave pipeline:
  - Accept at cycle 0.
  - `r_request` fire at cycle 1.
  - `r_reply` fire at cycle 2.
  - `rsp_valid` at cycle 3.
- Write latency against the same slave:
  - Accept at cycle 0.
  - waddr fire at cycle 1.
  - wdata fire at cycle 2, since the slave gates wdata ready on the registered addr.
  - `w_reply` fire at cycle 3.
  - `rsp_valid` at cycle 4.
- Back-to-back: in the `rsp_valid` cycle the state is IDLE, so a new request can be accepted in that same cycle.
- Slave stalls (ready or valid held low) extend the current state indefinitely. There is no timeout.
- `rsp_rdata` and `rsp_resp` hold their values until the next completion.

## Structure
- `resp_t` and the OKAY/SLVERR encodings live in `BusPack`.
- Add `AxiMasterState_t` (the FSM enum) to `BusPack`; the verification monitor also decodes it.
- No sub-module: one FSM plus payload and response registers, about 150–200 lines.

## Test plan
- Read to 0x1000 against AxiSlavePipeline with a memory model returning 0xDEADBEEF_CAFEF00D, OKAY -> `rsp_valid` at cycle 3, `rsp_rdata`=0xDEADBEEF_CAFEF00D, `rsp_resp`=OKAY.
- Write 0x11223344_55667788 with mask 0x0F to 0x2000 -> `rsp_valid` at cycle 4, `rsp_rdata`=0. A read-back of 0x2000 returns 0x????????_55667788 with the upper bytes unchanged.
- Slave wdata ready held low for 5 cycles, with the waddr fire in the first cycle -> `w_data_request_valid` and bits stay stable all 5 cycles and `w_addr_request_valid` drops after its fire. `rsp_valid` arrives 5 cycles late.
- `req_valid` held high with 3 alternating read/write requests -> each request is accepted exactly in the `rsp_valid` cycle of the previous one. 3 responses in order; no request is dropped or duplicated.
- `rstn` pulled low for 1 cycle in R_DATA -> all valids and readies are 0 the next cycle, no `rsp_valid`, `req_ready`=1. A following read completes normally.
- Slave returns SLVERR on a read -> `rsp_resp`=SLVERR and `rsp_rdata` holds the returned data.

Source files
------------

// File: rtl/BusPack.sv
// Shared types for the AXI memory pipeline: bus response codes and the core-side master FSM states.
package BusPack;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   // Also decoded by the verification monitor, so the encoding order matters.
   typedef enum logic [2:0] {
      IDLE,
      R_ADDR,
      R_DATA,
      W_REQ,
      W_RESP
   } AxiMasterState_t;

endpackage

// File: rtl/Axi_ift.sv
// Five-channel AXI-style bus between the core master and the slave memory pipeline.
interface Axi_ift
   import BusPack::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);

   logic                    r_request_valid;
   logic                    r_request_ready;
   logic [ADDR_WIDTH-1:0]   raddr;

   logic                    r_reply_valid;
   logic                    r_reply_ready;
   logic [DATA_WIDTH-1:0]   rdata;
   resp_t                   rresp;

   logic                    w_addr_request_valid;
   logic                    w_addr_request_ready;
   logic [ADDR_WIDTH-1:0]   waddr;

   logic                    w_data_request_valid;
   logic                    w_data_request_ready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;

   logic                    w_reply_valid;
   logic                    w_reply_ready;
   resp_t                   bresp;

   modport Master (
      output r_request_valid, raddr, r_reply_ready,
      output w_addr_request_valid, waddr,
      output w_data_request_valid, wdata, wstrb,
      output w_reply_ready,
      input  r_request_ready, r_reply_valid, rdata, rresp,
      input  w_addr_request_ready, w_data_request_ready,
      input  w_reply_valid, bresp
   );

   modport Slave (
      input  r_request_valid, raddr, r_reply_ready,
      input  w_addr_request_valid, waddr,
      input  w_data_request_valid, wdata, wstrb,
      input  w_reply_ready,
      output r_request_ready, r_reply_valid, rdata, rresp,
      output w_addr_request_ready, w_data_request_ready,
      output w_reply_valid, bresp
   );

endinterface

// File: rtl/axi_core_master.sv
// Single-outstanding load/store master: turns one core request into AXI channel traffic
// and returns read data or a write acknowledgement with the bus response code.
module axi_core_master
   import BusPack::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wen,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wmask,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output resp_t                   rsp_resp,
   Axi_ift.Master                  mem_ift
);

   generate
      if ((ADDR_WIDTH != mem_ift.ADDR_WIDTH) || (DATA_WIDTH != mem_ift.DATA_WIDTH)) begin : gWidthCheck
         $fatal(1, "axi_core_master: ADDR_WIDTH/DATA_WIDTH do not match mem_ift");
      end
   endgenerate

   AxiMasterState_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
   logic                    awDone_q, awDone_d;
   logic                    wDone_q, wDone_d;
   logic                    rspValid_q, rspValid_d;
   logic [DATA_WIDTH-1:0]   rspRdata_q, rspRdata_d;
   resp_t                   rspResp_q, rspResp_d;

   logic rReqFire, rRepFire, awFire, wFire, bFire;

   assign rReqFire = mem_ift.r_request_valid      & mem_ift.r_request_ready;
   assign rRepFire = mem_ift.r_reply_valid        & mem_ift.r_reply_ready;
   assign awFire   = mem_ift.w_addr_request_valid & mem_ift.w_addr_request_ready;
   assign wFire    = mem_ift.w_data_request_valid & mem_ift.w_data_request_ready;
   assign bFire    = mem_ift.w_reply_valid        & mem_ift.w_reply_ready;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      awDone_d   = awDone_q;
      wDone_d    = wDone_q;
      rspValid_d = 1'b0;
      rspRdata_d = rspRdata_q;
      rspResp_d  = rspResp_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               wmask_d  = req_wmask;
               awDone_d = 1'b0;
               wDone_d  = 1'b0;
               state_d  = req_wen ? W_REQ : R_ADDR;
            end
         end
         R_ADDR: begin
            if (rReqFire) state_d = R_DATA;
         end
         R_DATA: begin
            if (rRepFire) begin
               rspValid_d = 1'b1;
               rspRdata_d = mem_ift.rdata;
               rspResp_d  = mem_ift.rresp;
               state_d    = IDLE;
            end
         end
         W_REQ: begin
            // Address and data channels complete independently, in any order or together.
            if (awFire) awDone_d = 1'b1;
            if (wFire)  wDone_d  = 1'b1;
            if (awDone_d && wDone_d) state_d = W_RESP;
         end
         W_RESP: begin
            if (bFire) begin
               rspValid_d = 1'b1;
               rspRdata_d = '0;
               rspResp_d  = mem_ift.bresp;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         awDone_q   <= 1'b0;
         wDone_q    <= 1'b0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspResp_q  <= OKAY;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         awDone_q   <= awDone_d;
         wDone_q    <= wDone_d;
         rspValid_q <= rspValid_d;
         rspRdata_q <= rspRdata_d;
         rspResp_q  <= rspResp_d;
      end
   end

   // Valids depend only on registered state, so they never wait on a ready.
   assign req_ready                    = (state_q == IDLE);
   assign mem_ift.r_request_valid      = (state_q == R_ADDR);
   assign mem_ift.raddr                = addr_q;
   assign mem_ift.r_reply_ready        = (state_q == R_DATA);
   assign mem_ift.w_addr_request_valid = (state_q == W_REQ) && !awDone_q;
   assign mem_ift.waddr                = addr_q;
   assign mem_ift.w_data_request_valid = (state_q == W_REQ) && !wDone_q;
   assign mem_ift.wdata                = wdata_q;
   assign mem_ift.wstrb                = wmask_q;
   assign mem_ift.w_reply_ready        = (state_q == W_RESP);

   assign rsp_valid = rspValid_q;
   assign rsp_rdata = rspRdata_q;
   assign rsp_resp  = rspResp_q;

endmodule

// File: tb/tb_axi_core_master.sv
// Directed bench for axi_core_master against a small zero-wait slave model with a 16-word memory.
module tb_axi_core_master;
   import BusPack::*;

   localparam int AW = 64;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wen = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [7:0]    req_wmask = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   resp_t         rsp_resp;

   int assertCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   Axi_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi_core_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .mem_ift   (axi)
   );

   // Slave model: reads reply one cycle after the request, wdata ready waits on a held address.
   logic [63:0] mem [16];
   logic        memInit = 1'b0;
   logic        rPend_q, awHeld_q, bPend_q;
   logic [63:0] rData_q;
   int          wStall_q;
   int          wStallCfg = 0;
   logic        slverrCfg = 1'b0;

   function automatic logic [63:0] mergeBytes(input logic [63:0] oldVal, input logic [63:0] newVal,
                                              input logic [7:0] strb);
      logic [63:0] res;
      res = oldVal;
      for (int b = 0; b < 8; b++)
         if (strb[b]) res[b*8 +: 8] = newVal[b*8 +: 8];
      return res;
   endfunction

   assign axi.r_request_ready      = ~rPend_q;
   assign axi.r_reply_valid        = rPend_q;
   assign axi.rdata                = rData_q;
   assign axi.rresp                = slverrCfg ? SLVERR : OKAY;
   assign axi.w_addr_request_ready = ~awHeld_q;
   assign axi.w_data_request_ready = awHeld_q && (wStall_q == 0);
   assign axi.w_reply_valid        = bPend_q;
   assign axi.bresp                = OKAY;

   always @(posedge clk) begin
      if (!memInit) begin
         for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
         mem[1]  <= 64'hDEADBEEF_CAFEF00D;
         mem[2]  <= 64'hA1A2A3A4_B1B2B3B4;
         memInit <= 1'b1;
      end
      if (!rstn) begin
         rPend_q  <= 1'b0;
         rData_q  <= 64'h0;
         awHeld_q <= 1'b0;
         wStall_q <= 0;
         bPend_q  <= 1'b0;
      end else begin
         if (axi.r_request_valid && axi.r_request_ready) begin
            rPend_q <= 1'b1;
            rData_q <= mem[axi.raddr[15:12]];
         end else if (axi.r_reply_valid && axi.r_reply_ready) begin
            rPend_q <= 1'b0;
         end
         if (axi.w_addr_request_valid && axi.w_addr_request_ready) begin
            awHeld_q <= 1'b1;
            wStall_q <= wStallCfg;
         end else if (awHeld_q && wStall_q != 0) begin
            wStall_q <= wStall_q - 1;
         end
         if (axi.w_data_request_valid && axi.w_data_request_ready) begin
            awHeld_q <= 1'b0;
            bPend_q  <= 1'b1;
            mem[axi.waddr[15:12]] <= mergeBytes(mem[axi.waddr[15:12]], axi.wdata, axi.wstrb);
         end
         if (axi.w_reply_valid && axi.w_reply_ready) bPend_q <= 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called #1 after an edge with the DUT idle; returns in the rsp_valid cycle (or on timeout).
   task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [7:0] wmask, input bit holdValid,
                                output int lat, output logic [63:0] rdata, output logic [1:0] resp);
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!holdValid) req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rdata = rsp_rdata;
      resp  = rsp_resp;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      logic [63:0] rd;
      logic [1:0]  rs;

      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset req_ready", 64'(req_ready), 64'd1);
      checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset rsp_rdata", rsp_rdata, 64'd0);
      checkOutput("reset rsp_resp", 64'(rsp_resp), 64'd0);
      checkOutput("reset r_request_valid", 64'(axi.r_request_valid), 64'd0);
      checkOutput("reset r_reply_ready", 64'(axi.r_reply_ready), 64'd0);
      checkOutput("reset w_addr_valid", 64'(axi.w_addr_request_valid), 64'd0);
      checkOutput("reset w_data_valid", 64'(axi.w_data_request_valid), 64'd0);
      checkOutput("reset w_reply_ready", 64'(axi.w_reply_ready), 64'd0);
      checkOutput("reset raddr", axi.raddr, 64'd0);
      checkOutput("reset wdata", axi.wdata, 64'd0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic read");
      applyStimulus(1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, lat, rd, rs);
      checkOutput("read latency", 64'(lat), 64'd3);
      checkOutput("read data", rd, 64'hDEADBEEF_CAFEF00D);
      checkOutput("read resp", 64'(rs), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("pulse one cycle", 64'(rsp_valid), 64'd0);
      checkOutput("rdata holds", rsp_rdata, 64'hDEADBEEF_CAFEF00D);

      $display("[TB] masked write and read-back");
      applyStimulus(1'b1, 64'h2000, 64'h11223344_55667788, 8'h0F, 1'b0, lat, rd, rs);
      checkOutput("write latency", 64'(lat), 64'd4);
      checkOutput("write rdata zero", rd, 64'd0);
      checkOutput("write resp", 64'(rs), 64'd0);
      applyStimulus(1'b0, 64'h2000, 64'h0, 8'h00, 1'b0, lat, rd, rs);
      checkOutput("readback data", rd, 64'hA1A2A3A4_55667788);

      $display("[TB] zero-mask write still issued");
      applyStimulus(1'b1, 64'h2000, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 1'b0, lat, rd, rs);
      checkOutput("zero-mask latency", 64'(lat), 64'd4);
      applyStimulus(1'b0, 64'h2000, 64'h0, 8'h00, 1'b0, lat, rd, rs);
      checkOutput("zero-mask readback", rd, 64'hA1A2A3A4_55667788);

      $display("[TB] wdata stall");
      wStallCfg = 5;
      req_wen   = 1'b1;
      req_addr  = 64'h3000;
      req_wdata = 64'hCAFE0000_12345678;
      req_wmask = 8'hFF;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("stall c1 aw valid", 64'(axi.w_addr_request_valid), 64'd1);
      checkOutput("stall c1 w valid", 64'(axi.w_data_request_valid), 64'd1);
      checkOutput("stall c1 waddr", axi.waddr, 64'h3000);
      for (int c = 2; c <= 6; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("stall c%0d aw valid", c), 64'(axi.w_addr_request_valid), 64'd0);
         checkOutput($sformatf("stall c%0d w valid", c), 64'(axi.w_data_request_valid), 64'd1);
         checkOutput($sformatf("stall c%0d wdata", c), axi.wdata, 64'hCAFE0000_12345678);
         checkOutput($sformatf("stall c%0d wstrb", c), 64'(axi.wstrb), 64'hFF);
      end
      lat = 6;
      while (!rsp_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      wStallCfg = 0;
      checkOutput("stall latency", 64'(lat), 64'd9);
      applyStimulus(1'b0, 64'h3000, 64'h0, 8'h00, 1'b0, lat, rd, rs);
      checkOutput("stall readback", rd, 64'hCAFE0000_12345678);

      $display("[TB] back-to-back with req_valid held");
      applyStimulus(1'b0, 64'h1000, 64'h0, 8'h00, 1'b1, lat, rd, rs);
      checkOutput("b2b r1 latency", 64'(lat), 64'd3);
      checkOutput("b2b r1 data", rd, 64'hDEADBEEF_CAFEF00D);
      checkOutput("b2b ready in rsp cycle", 64'(req_ready), 64'd1);
      applyStimulus(1'b1, 64'h4000, 64'h01234567_89ABCDEF, 8'hFF, 1'b1, lat, rd, rs);
      checkOutput("b2b w2 latency", 64'(lat), 64'd4);
      checkOutput("b2b w2 rdata", rd, 64'd0);
      applyStimulus(1'b0, 64'h4000, 64'h0, 8'h00, 1'b0, lat, rd, rs);
      checkOutput("b2b r3 latency", 64'(lat), 64'd3);
      checkOutput("b2b r3 data", rd, 64'h01234567_89ABCDEF);

      $display("[TB] reset in R_DATA");
      req_wen   = 1'b0;
      req_addr  = 64'h1000;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("in R_DATA", 64'(axi.r_reply_ready), 64'd1);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      checkOutput("mid-reset r_request_valid", 64'(axi.r_request_valid), 64'd0);
      checkOutput("mid-reset r_reply_ready", 64'(axi.r_reply_ready), 64'd0);
      checkOutput("mid-reset w_addr_valid", 64'(axi.w_addr_request_valid), 64'd0);
      checkOutput("mid-reset w_data_valid", 64'(axi.w_data_request_valid), 64'd0);
      checkOutput("mid-reset w_reply_ready", 64'(axi.w_reply_ready), 64'd0);
      checkOutput("mid-reset rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("mid-reset rsp_rdata", rsp_rdata, 64'd0);
      checkOutput("mid-reset req_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("post-reset rsp_valid", 64'(rsp_valid), 64'd0);
      applyStimulus(1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, lat, rd, rs);
      checkOutput("post-reset latency", 64'(lat), 64'd3);
      checkOutput("post-reset data", rd, 64'hDEADBEEF_CAFEF00D);

      $display("[TB] read with SLVERR");
      slverrCfg = 1'b1;
      applyStimulus(1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, lat, rd, rs);
      slverrCfg = 1'b0;
      checkOutput("slverr resp", 64'(rs), 64'd2);
      checkOutput("slverr data", rd, 64'hDEADBEEF_CAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
